// File: rtl/psum_accum_ctrl.sv
// Pass sequencer and wrap-around accumulator wrapped around a pipelined adder tree.
// Optional build macro PSUM_RELU_EN clamps negative results to zero at the output register.
module psum_accum_ctrl #(
  parameter  int PAR        = 9,
  parameter  int ACC_W      = 48,
  parameter  int MAX_PASSES = 64,
  localparam int CNT_W      = $clog2(MAX_PASSES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_passes,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAR*ACC_W-1:0] in_vec,
  output logic                 tree_valid_in,
  output logic [PAR*ACC_W-1:0] tree_in_vec,
  input  logic                 tree_valid_out,
  input  logic [ACC_W-1:0]     tree_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 err_unexpected
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     n_r;
  logic [CNT_W-1:0]     issued_r;
  logic [CNT_W-1:0]     rcvd_r;
  logic [ACC_W-1:0]     acc_r;
  logic                 zjob_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 in_ready_r;
  logic                 tree_valid_in_r;
  logic [PAR*ACC_W-1:0] tree_in_vec_r;
  logic                 out_valid_r;
  logic [ACC_W-1:0]     out_data_r;
  logic                 err_r;

  logic                 accept_s;
  logic                 ret_ok_s;
  logic [ACC_W-1:0]     acc_next_s;
  logic [CNT_W-1:0]     rcvd_next_s;

  function automatic logic [ACC_W-1:0] out_fmt(input logic [ACC_W-1:0] v);
`ifdef PSUM_RELU_EN
    out_fmt = v[ACC_W-1] ? {ACC_W{1'b0}} : v;
`else
    out_fmt = v;
`endif
  endfunction

  // Issue handshake and return-path bookkeeping; a return only counts while a sum is still owed.
  always_comb begin
    accept_s    = in_valid && in_ready_r;
    ret_ok_s    = 1'b0;
    acc_next_s  = acc_r;
    rcvd_next_s = rcvd_r;
    if (tree_valid_out && (state_r == FEED || state_r == DRAIN) && (rcvd_r < n_r)) begin
      ret_ok_s    = 1'b1;
      acc_next_s  = acc_r + tree_sum;
      rcvd_next_s = rcvd_r + CNT_W'(1);
    end else begin
      ret_ok_s    = 1'b0;
    end
  end

  // Job FSM, counters, accumulator and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      n_r             <= {CNT_W{1'b0}};
      issued_r        <= {CNT_W{1'b0}};
      rcvd_r          <= {CNT_W{1'b0}};
      acc_r           <= {ACC_W{1'b0}};
      zjob_r          <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      in_ready_r      <= 1'b0;
      tree_valid_in_r <= 1'b0;
      tree_in_vec_r   <= {(PAR*ACC_W){1'b0}};
      out_valid_r     <= 1'b0;
      out_data_r      <= {ACC_W{1'b0}};
      err_r           <= 1'b0;
    end else begin
      done_r          <= 1'b0;
      tree_valid_in_r <= accept_s;
      if (accept_s) begin
        tree_in_vec_r <= in_vec;
      end
      if (tree_valid_out && !ret_ok_s) begin
        err_r <= 1'b1;
      end
      acc_r  <= acc_next_s;
      rcvd_r <= rcvd_next_s;
      case (state_r)
        IDLE: begin
          if (zjob_r) begin
            // Zero-pass job: one busy cycle, then done without touching the datapath.
            zjob_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else if (start && !done_r) begin
            busy_r <= 1'b1;
            if (num_passes == {CNT_W{1'b0}}) begin
              zjob_r <= 1'b1;
            end else begin
              n_r        <= num_passes;
              issued_r   <= {CNT_W{1'b0}};
              rcvd_r     <= {CNT_W{1'b0}};
              acc_r      <= {ACC_W{1'b0}};
              in_ready_r <= 1'b1;
              state_r    <= FEED;
            end
          end
        end
        FEED: begin
          if (accept_s) begin
            issued_r <= issued_r + CNT_W'(1);
            if (issued_r == n_r - CNT_W'(1)) begin
              in_ready_r <= 1'b0;
              state_r    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rcvd_next_s == n_r) begin
            out_valid_r <= 1'b1;
            out_data_r  <= out_fmt(acc_next_s);
            state_r     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign in_ready       = in_ready_r;
  assign tree_valid_in  = tree_valid_in_r;
  assign tree_in_vec    = tree_in_vec_r;
  assign out_valid      = out_valid_r;
  assign out_data       = out_data_r;
  assign err_unexpected = err_r;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Randomised bench for psum_accum_ctrl with a behavioural 4-cycle adder tree and a sum-of-lanes reference.
module tb_psum_accum_ctrl;
  localparam int PAR   = 9;
  localparam int ACC_W = 48;
  localparam int CNT_W = 7;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [CNT_W-1:0]     num_passes = '0;
  logic                 busy, done, in_ready, tree_valid_in, out_valid, err_unexpected;
  logic                 in_valid = 1'b0;
  logic [PAR*ACC_W-1:0] in_vec = '0;
  logic [PAR*ACC_W-1:0] tree_in_vec;
  logic                 tree_valid_out;
  logic [ACC_W-1:0]     tree_sum;
  logic                 out_ready = 1'b0;
  logic [ACC_W-1:0]     out_data;
  logic                 inj = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  psum_accum_ctrl #(.PAR(PAR), .ACC_W(ACC_W), .MAX_PASSES(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_passes(num_passes),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .tree_valid_in(tree_valid_in), .tree_in_vec(tree_in_vec),
    .tree_valid_out(tree_valid_out), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  function automatic logic [ACC_W-1:0] lane_sum(input logic [PAR*ACC_W-1:0] v);
    logic [ACC_W-1:0] s;
    s = '0;
    for (int i = 0; i < PAR; i++) s = s + v[i*ACC_W +: ACC_W];
    return s;
  endfunction

  // Behavioural adder tree: fixed latency of 4, flushed by reset.
  logic [3:0]       pv;
  logic [ACC_W-1:0] ps [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) ps[i] <= '0;
    end else begin
      pv    <= {pv[2:0], tree_valid_in};
      ps[0] <= lane_sum(tree_in_vec);
      for (int i = 1; i < 4; i++) ps[i] <= ps[i-1];
    end
  end
  assign tree_valid_out = pv[3] | inj;
  assign tree_sum       = ps[3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: all ones, 1: lane i = i+1, 2: lane i = -i, 3: random, 4: pass 0 as mode 2 then mode 0
  function automatic logic [PAR*ACC_W-1:0] gen_vec(input int mode, input int k);
    logic [PAR*ACC_W-1:0] v;
    logic [ACC_W-1:0] l;
    for (int i = 0; i < PAR; i++) begin
      case (mode)
        0: l = 48'd1;
        1: l = ACC_W'(i + 1);
        2: l = -ACC_W'(i);
        3: l = ACC_W'({$urandom, $urandom});
        default: l = (k == 0) ? -ACC_W'(i) : 48'd1;
      endcase
      v[i*ACC_W +: ACC_W] = l;
    end
    return v;
  endfunction

  task automatic run_job(input int n, input int mode, input bit b2b, input int hold,
                         input string tag, output logic [ACC_W-1:0] got);
    logic [ACC_W-1:0] exp;
    int k, rdy;
    bit seen;
    exp = '0; k = 0; rdy = 0; seen = 0;
    start = 1'b1;
    num_passes = CNT_W'(n);
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
      end
      if (out_valid) seen = 1;
      else begin
        if (in_ready) rdy++;
        in_valid = 1'b0;
        if (in_ready && k < n && (b2b || $urandom_range(1, 0) == 1)) begin
          in_vec   = gen_vec(mode, k);
          in_valid = 1'b1;
          exp      = exp + lane_sum(in_vec);
          k++;
        end
      end
    end
    in_valid = 1'b0;
    if (!seen) check({tag, "_timeout"}, 0, 1);
`ifdef PSUM_RELU_EN
    if (exp[ACC_W-1]) exp = '0;
`endif
    got = out_data;
    check({tag, "_data"}, out_data, exp);
    check({tag, "_err"}, err_unexpected, 0);
    if (b2b) check({tag, "_rdycyc"}, rdy, n);
    out_ready = (hold == 0);
    start = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, "_hold_v"}, out_valid, 1);
      check({tag, "_hold_d"}, out_data, got);
      check({tag, "_hold_b"}, busy, 1);
      check({tag, "_hold_r"}, {in_ready, tree_valid_in}, 0);
      if (h == hold - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done"}, {out_valid, done, busy}, 3'b010);
    @(negedge clk);
    check({tag, "_idle"}, {out_valid, done, busy, in_ready}, 4'b0000);
  endtask

  logic [ACC_W-1:0] got;
  logic [ACC_W-1:0] neg27;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outs", {busy, done, in_ready, tree_valid_in, out_valid, err_unexpected}, 0);
    check("rst_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(1, 0, 1'b1, 0, "t1", got);
    check("t1_nine", got, 48'd9);
    run_job(3, 1, 1'b1, 0, "t2", got);
    check("t2_135", got, 48'd135);
    run_job(2, 4, 1'b1, 0, "t3", got);
    neg27 = -48'd27;
`ifdef PSUM_RELU_EN
    neg27 = 48'd0;
`endif
    check("t3_neg", got, neg27);
    run_job(1, 0, 1'b1, 5, "t4", got);
    check("t4_nine", got, 48'd9);

    // zero-pass job
    start = 1'b1; num_passes = '0;
    @(negedge clk);
    start = 1'b0;
    check("t5_c1", {busy, done, out_valid, in_ready, tree_valid_in}, 5'b10000);
    @(negedge clk);
    check("t5_c2", {busy, done, out_valid, in_ready, tree_valid_in}, 5'b01000);
    @(negedge clk);
    check("t5_c3", {busy, done, out_valid, in_ready, tree_valid_in}, 5'b00000);

    // reset in the middle of a 4-pass job after two issues
    start = 1'b1; num_passes = CNT_W'(4);
    @(negedge clk);
    start = 1'b0;
    in_vec = gen_vec(0, 0); in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("t6_rst", {busy, done, in_ready, tree_valid_in, out_valid, err_unexpected}, 0);
    check("t6_rstd", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_quiet", {busy, err_unexpected, out_valid}, 0);
    run_job(1, 0, 1'b1, 0, "t6b", got);
    check("t6b_nine", got, 48'd9);

    run_job(64, 3, 1'b1, 1, "maxn", got);
    for (int j = 0; j < 16; j++)
      run_job($urandom_range(12, 1), 3, 1'(($urandom_range(1, 0))), $urandom_range(3, 0), "rnd", got);

    // spurious tree result while idle must latch the sticky error
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    check("err_sticky", err_unexpected, 1);
    @(negedge clk);
    check("err_hold", {err_unexpected, busy}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
